// File: rtl/renkon_layer_seq.sv
// Purpose : per-layer sequencer feeding the renkon conv-engine controller from a host-written layer table.
// Latency : start -> req in 2 cycles; ack -> next req in 2 cycles, or done in 1 cycle.
// Backpr. : one req per layer; the sequencer holds in WAIT until the controller acks. abort cancels at once.
// Ports   : clk/xrst (sync, active-high); prm_* table write port; num_layers/start/abort control;
//           ack in / req out handshake; per-layer config outputs (offsets, geometry, enables);
//           busy, layer_idx, done and aborted status.
module renkon_layer_seq #(
   parameter  int N_LAYER = 16,
   parameter  int LWIDTH  = 16,
   parameter  int MEMSIZE = 12,
   parameter  int NETSIZE = 11,
   localparam int IW      = $clog2(N_LAYER),
   localparam int NW      = IW + 1
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               prm_we,
   input  logic [IW-1:0]      prm_layer,
   input  logic [3:0]         prm_field,
   input  logic [31:0]        prm_wdata,
   input  logic [NW-1:0]      num_layers,
   input  logic               start,
   input  logic               abort,
   input  logic               ack,
   output logic               req,
   output logic [MEMSIZE-1:0] in_offset,
   output logic [MEMSIZE-1:0] out_offset,
   output logic [NETSIZE-1:0] net_offset,
   output logic [LWIDTH-1:0]  total_in,
   output logic [LWIDTH-1:0]  total_out,
   output logic [LWIDTH-1:0]  img_height,
   output logic [LWIDTH-1:0]  img_width,
   output logic [LWIDTH-1:0]  conv_kern,
   output logic [LWIDTH-1:0]  conv_strid,
   output logic [LWIDTH-1:0]  conv_pad,
   output logic [LWIDTH-1:0]  pool_kern,
   output logic [LWIDTH-1:0]  pool_strid,
   output logic [LWIDTH-1:0]  pool_pad,
   output logic               bias_en,
   output logic               relu_en,
   output logic               pool_en,
   output logic               busy,
   output logic [IW-1:0]      layer_idx,
   output logic               done,
   output logic               aborted
);

   typedef struct packed {
      logic [MEMSIZE-1:0] in_off;
      logic [MEMSIZE-1:0] out_off;
      logic [NETSIZE-1:0] net_off;
      logic [LWIDTH-1:0]  total_in;
      logic [LWIDTH-1:0]  total_out;
      logic [LWIDTH-1:0]  height;
      logic [LWIDTH-1:0]  width;
      logic [LWIDTH-1:0]  conv_kern;
      logic [LWIDTH-1:0]  conv_strid;
      logic [LWIDTH-1:0]  conv_pad;
      logic [2:0]         flags;      // {pool, relu, bias}
      logic [LWIDTH-1:0]  pool_kern;
      logic [LWIDTH-1:0]  pool_strid;
      logic [LWIDTH-1:0]  pool_pad;
   } layer_t;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [NW-1:0]   n_q, n_d;
   logic            aborted_q, aborted_d;
   logic            load_en;
   layer_t          cfg_q;
   layer_t          tbl_q [N_LAYER];
   logic            wr_en;
   logic            unused_wdata;

   // Only the low bits of prm_wdata are ever stored; wider values are truncated.
   assign unused_wdata = ^prm_wdata;

   // The row currently being run is frozen so a running layer never sees a torn config.
   assign wr_en = prm_we && !(busy && (prm_layer == idx_q));

   // Table is plain storage with no reset: contents are undefined until the host writes them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         case (prm_field)
            4'd0:  tbl_q[prm_layer].in_off     <= prm_wdata[MEMSIZE-1:0];
            4'd1:  tbl_q[prm_layer].out_off    <= prm_wdata[MEMSIZE-1:0];
            4'd2:  tbl_q[prm_layer].net_off    <= prm_wdata[NETSIZE-1:0];
            4'd3:  tbl_q[prm_layer].total_in   <= prm_wdata[LWIDTH-1:0];
            4'd4:  tbl_q[prm_layer].total_out  <= prm_wdata[LWIDTH-1:0];
            4'd5:  tbl_q[prm_layer].height     <= prm_wdata[LWIDTH-1:0];
            4'd6:  tbl_q[prm_layer].width      <= prm_wdata[LWIDTH-1:0];
            4'd7:  tbl_q[prm_layer].conv_kern  <= prm_wdata[LWIDTH-1:0];
            4'd8:  tbl_q[prm_layer].conv_strid <= prm_wdata[LWIDTH-1:0];
            4'd9:  tbl_q[prm_layer].conv_pad   <= prm_wdata[LWIDTH-1:0];
            4'd10: tbl_q[prm_layer].flags      <= prm_wdata[2:0];
            4'd11: tbl_q[prm_layer].pool_kern  <= prm_wdata[LWIDTH-1:0];
            4'd12: tbl_q[prm_layer].pool_strid <= prm_wdata[LWIDTH-1:0];
            4'd13: tbl_q[prm_layer].pool_pad   <= prm_wdata[LWIDTH-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      aborted_d = 1'b0;
      load_en   = 1'b0;
      if (abort && (state_q != S_IDLE)) begin
         // abort wins over any same-cycle ack, so idx is not advanced.
         state_d   = S_IDLE;
         aborted_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               state_d = S_LOAD;
               idx_d   = '0;
               n_d     = (num_layers > NW'(N_LAYER)) ? NW'(N_LAYER) : num_layers;
            end
            // An empty sequence passes through LOAD without touching the config outputs.
            S_LOAD: if (n_q == '0) begin
               state_d = S_DONE;
            end else begin
               load_en = 1'b1;
               state_d = S_REQ;
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (ack) begin
               if ({1'b0, idx_q} == (n_q - NW'(1))) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_LOAD;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         n_q       <= '0;
         aborted_q <= 1'b0;
         cfg_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         aborted_q <= aborted_d;
         if (load_en) cfg_q <= tbl_q[idx_q];
      end
   end

   // abort suppresses the pulses of the cycle it arrives in.
   assign req        = (state_q == S_REQ)  && !abort;
   assign done       = (state_q == S_DONE) && !abort;
   assign busy       = (state_q != S_IDLE);
   assign aborted    = aborted_q;
   assign layer_idx  = idx_q;

   assign in_offset  = cfg_q.in_off;
   assign out_offset = cfg_q.out_off;
   assign net_offset = cfg_q.net_off;
   assign total_in   = cfg_q.total_in;
   assign total_out  = cfg_q.total_out;
   assign img_height = cfg_q.height;
   assign img_width  = cfg_q.width;
   assign conv_kern  = cfg_q.conv_kern;
   assign conv_strid = cfg_q.conv_strid;
   assign conv_pad   = cfg_q.conv_pad;
   assign pool_kern  = cfg_q.pool_kern;
   assign pool_strid = cfg_q.pool_strid;
   assign pool_pad   = cfg_q.pool_pad;
   assign bias_en    = cfg_q.flags[0];
   assign relu_en    = cfg_q.flags[1];
   assign pool_en    = cfg_q.flags[2];

endmodule
